// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding,
// counter width and default phase lengths.
package pulse_stretch_pkg;

  localparam int CNT_W               = 8;
  localparam int DEFAULT_HIGH_CYCLES = 4;
  localparam int DEFAULT_LOW_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretch_if.sv
// Tick request and stretched-pulse status bundle; the stretcher is the slave.
interface pulse_stretch_if;
  import pulse_stretch_pkg::*;

  logic             tick;
  logic             level;
  logic             busy;
  logic             drop_tick;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (output tick, input level, busy, drop_tick, pulse_cnt);
  modport slave  (input tick, output level, busy, drop_tick, pulse_cnt);

endinterface

// File: rtl/pulse_stretch_load_down_counter.sv
// Loadable down counter that saturates at zero; times both the HIGH and GAP
// phases of the pulse stretcher.
module load_down_counter
  import pulse_stretch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle ticks into HIGH_CYCLES-long pulses followed by a
// LOW_CYCLES gap. Define PULSE_STRETCH_RETRIGGER_EN to let a tick during the
// high phase restart it; otherwise such ticks are dropped.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEFAULT_LOW_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  pulse_stretch_if.slave bus
);

  if (HIGH_CYCLES < 1 || HIGH_CYCLES > 255) begin : g_bad_high
    $error("pulse_stretch: HIGH_CYCLES must be in 1..255");
  end
  if (LOW_CYCLES > 255) begin : g_bad_low
    $error("pulse_stretch: LOW_CYCLES must be in 0..255");
  end

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'((LOW_CYCLES == 0) ? 0 : LOW_CYCLES - 1);

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             drop_tick_q, drop_tick_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;

  load_down_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    drop_tick_d  = 1'b0;
    pulse_cnt_d  = pulse_cnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = HIGH_LOAD;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.tick) begin
          state_d     = ST_HIGH;
          cnt_load    = 1'b1;
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        end
      end

      ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (bus.tick) begin
          cnt_load    = 1'b1;
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        end else if (cnt_zero) begin
`else
        drop_tick_d = bus.tick;
        if (cnt_zero) begin
`endif
          // With no gap configured the pulse ends straight back in IDLE.
          if (LOW_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = LOW_LOAD;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_GAP: begin
        drop_tick_d = bus.tick;
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    level_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      level_q     <= 1'b0;
      busy_q      <= 1'b0;
      drop_tick_q <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      busy_q      <= busy_d;
      drop_tick_q <= drop_tick_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign bus.level     = level_q;
  assign bus.busy      = busy_q;
  assign bus.drop_tick = drop_tick_q;
  assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: a default instance plus a HIGH=1/LOW=0
// instance for the continuous-tick wrap test. Honours PULSE_STRETCH_RETRIGGER_EN.
module tb_pulse_stretch;

  logic clk;
  logic rst;
  int   edge_n;
  int   n_checks;
  int   n_pass;

  pulse_stretch_if main_if ();
  pulse_stretch_if fast_if ();

  pulse_stretch dut (
    .clk (clk),
    .rst (rst),
    .bus (main_if)
  );

  pulse_stretch #(.HIGH_CYCLES(1), .LOW_CYCLES(0)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (fast_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic t, input logic r);
    main_if.tick = t;
    rst          = r;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic checkAll(input string tag, input logic lvl, input logic bsy, input logic drp, input logic [7:0] cnt);
    checkOutput({tag, ".level"}, {7'd0, main_if.level}, {7'd0, lvl});
    checkOutput({tag, ".busy"}, {7'd0, main_if.busy}, {7'd0, bsy});
    checkOutput({tag, ".drop"}, {7'd0, main_if.drop_tick}, {7'd0, drp});
    checkOutput({tag, ".cnt"}, main_if.pulse_cnt, cnt);
  endtask

  // Two reset edges; the last one becomes edge 0 of the next scenario.
  task automatic resetDut();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    edge_n = 0;
  endtask

  task automatic runTo(input int target);
    while (edge_n < target) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    logic       exp_lvl;
    logic       exp_drp;
    logic [7:0] exp_cnt;
    int         c;

    n_checks     = 0;
    n_pass       = 0;
    edge_n       = 0;
    rst          = 1'b1;
    main_if.tick = 1'b0;
    fast_if.tick = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'((i % 2) == 1), 1'b1);
      checkAll($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 8'd0);
    end

    resetDut();
    runTo(19);
    for (int e = 20; e <= 28; e++) begin
      applyStimulus(1'(e == 20), 1'b0);
      c = e + 1;
      checkAll($sformatf("single_c%0d", c), 1'(c >= 21 && c <= 24), 1'(c >= 21 && c <= 26), 1'b0, 8'd1);
    end

    resetDut();
    runTo(19);
    for (int e = 20; e <= 33; e++) begin
      applyStimulus(1'(e == 20 || e == 25 || e == 27), 1'b0);
      c = e + 1;
      checkAll($sformatf("gapdrop_c%0d", c),
               1'((c >= 21 && c <= 24) || (c >= 28 && c <= 31)),
               1'((c >= 21 && c <= 26) || (c >= 28 && c <= 33)),
               1'(c == 26),
               (c < 28) ? 8'd1 : 8'd2);
    end

    resetDut();
    runTo(19);
    for (int e = 20; e <= 29; e++) begin
      applyStimulus(1'(e == 20 || e == 22), 1'b0);
      c = e + 1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
      checkAll($sformatf("retrig_c%0d", c), 1'(c >= 21 && c <= 26), 1'(c >= 21 && c <= 28),
               1'b0, (c >= 23) ? 8'd2 : 8'd1);
`else
      checkAll($sformatf("highdrop_c%0d", c), 1'(c >= 21 && c <= 24), 1'(c >= 21 && c <= 26),
               1'(c == 23), 8'd1);
`endif
    end

    // Reset mid-pulse, with a simultaneous tick that must be ignored silently.
    resetDut();
    runTo(19);
    for (int e = 20; e <= 25; e++) begin
      applyStimulus(1'(e == 20 || e == 22 || e == 24), 1'(e == 22));
      c = e + 1;
      checkAll($sformatf("midrst_c%0d", c), 1'(c <= 22 || c >= 25), 1'(c <= 22 || c >= 25),
               1'b0, (c == 23 || c == 24) ? 8'd0 : 8'd1);
    end

    resetDut();
    exp_lvl      = 1'b0;
    exp_drp      = 1'b0;
    exp_cnt      = 8'd0;
    fast_if.tick = 1'b1;
    for (int i = 1; i <= 520; i++) begin
      applyStimulus(1'b0, 1'b0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
      exp_lvl = 1'b1;
      exp_drp = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
`else
      if (!exp_lvl) begin
        exp_lvl = 1'b1;
        exp_drp = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
      end else begin
        exp_lvl = 1'b0;
        exp_drp = 1'b1;
      end
`endif
      checkOutput($sformatf("fast%0d.level", i), {7'd0, fast_if.level}, {7'd0, exp_lvl});
      checkOutput($sformatf("fast%0d.drop", i), {7'd0, fast_if.drop_tick}, {7'd0, exp_drp});
      checkOutput($sformatf("fast%0d.cnt", i), fast_if.pulse_cnt, exp_cnt);
    end
`ifdef PULSE_STRETCH_RETRIGGER_EN
    checkOutput("fast_wrap_final", fast_if.pulse_cnt, 8'd8);
`else
    checkOutput("fast_wrap_final", fast_if.pulse_cnt, 8'd4);
`endif
    fast_if.tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
